// File: rtl/engagement_sequencer.sv
// rtl/engagement_sequencer.sv - radar scan arbitration, supervision and engagement handshake sequencer
module engagement_sequencer #(
    parameter int unsigned PATROL_PERIOD = 1000,
    parameter int unsigned SCAN_TIMEOUT  = 255,
    parameter int unsigned COOLDOWN      = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        pilot_req,
    input  logic [1:0]  artau_state,
    input  logic        threat_detected,
    input  logic [31:0] distance_to_target,
    input  logic [1:0]  ecsu_state,
    input  logic        emergency_landing_alert,
    input  logic        engage_ack,
    output logic        scan_for_target,
    output logic        pilot_gnt,
    output logic        engage_req,
    output logic [31:0] engage_distance,
    output logic        abort,
    output logic [7:0]  scan_count,
    output logic [7:0]  engage_count,
    output logic [2:0]  seq_state
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SCAN      = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_ENGAGE    = 3'd4,
        ST_HOLD      = 3'd5,
        ST_LOCKOUT   = 3'd6
    } state_t;

    localparam logic [1:0] ARTAU_IDLE     = 2'b00;
    localparam logic [1:0] ECSU_ALL_CLEAR = 2'b00;
    localparam logic [1:0] ECSU_CAUTION   = 2'b01;

    localparam int unsigned PAT_W   = $clog2(PATROL_PERIOD);
    localparam int unsigned CNT_MAX = (SCAN_TIMEOUT > COOLDOWN) ? SCAN_TIMEOUT : COOLDOWN;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [PAT_W-1:0] PAT_LAST = PAT_W'(PATROL_PERIOD - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(SCAN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CD_LAST  = CNT_W'(COOLDOWN - 1);

    state_t            state_q, state_d;
    logic [PAT_W-1:0]  patrol_cnt_q, patrol_cnt_d;
    logic              patrol_pending_q, patrol_pending_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              scan_q, scan_d;
    logic              gnt_q, gnt_d;
    logic              engage_req_q, engage_req_d;
    logic              abort_q, abort_d;
    logic [31:0]       engage_distance_q, engage_distance_d;
    logic [7:0]        scan_count_q, scan_count_d;
    logic [7:0]        engage_count_q, engage_count_d;

    logic              patrol_tc;
    logic              grant_patrol;
    logic              timeout;
    logic              weather_ok;
    logic              weather_bad;

    always_comb begin
        state_d           = state_q;
        scan_d            = 1'b0;
        gnt_d             = 1'b0;
        abort_d           = 1'b0;
        engage_distance_d = engage_distance_q;
        scan_count_d      = scan_count_q;
        engage_count_d    = engage_count_q;
        grant_patrol      = 1'b0;

        patrol_tc    = (patrol_cnt_q == PAT_LAST);
        patrol_cnt_d = patrol_tc ? '0 : patrol_cnt_q + 1'b1;
        timeout      = (wait_cnt_q == TO_LAST);
        weather_ok   = (ecsu_state == ECSU_ALL_CLEAR) || (ecsu_state == ECSU_CAUTION);
        weather_bad  = !weather_ok;

        // The landing alert pre-empts every state, including grants in IDLE.
        if (emergency_landing_alert) begin
            state_d = ST_LOCKOUT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pilot_req) begin
                        state_d = ST_SCAN;
                        scan_d  = 1'b1;
                        gnt_d   = 1'b1;
                    end else if (patrol_pending_q) begin
                        state_d      = ST_SCAN;
                        scan_d       = 1'b1;
                        grant_patrol = 1'b1;
                    end
                end
                ST_SCAN: state_d = ST_WAIT_BUSY;
                ST_WAIT_BUSY: begin
                    if (artau_state != ARTAU_IDLE) begin
                        state_d = ST_WAIT_DONE;
                    end else if (timeout) begin
                        state_d      = ST_HOLD;
                        abort_d      = 1'b1;
                        scan_count_d = scan_count_q + 8'd1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (threat_detected && weather_ok) begin
                        state_d           = ST_ENGAGE;
                        engage_distance_d = distance_to_target;
                    end else if (threat_detected) begin
                        state_d = ST_HOLD;
                    end else if (artau_state == ARTAU_IDLE) begin
                        state_d = ST_HOLD;
                    end else if (timeout) begin
                        state_d = ST_HOLD;
                        abort_d = 1'b1;
                    end
                    if (state_d != ST_WAIT_DONE) begin
                        scan_count_d = scan_count_q + 8'd1;
                    end
                end
                ST_ENGAGE: begin
                    if (engage_ack) begin
                        state_d        = ST_HOLD;
                        engage_count_d = engage_count_q + 8'd1;
                    end else if (weather_bad || timeout) begin
                        state_d = ST_HOLD;
                        abort_d = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (wait_cnt_q == CD_LAST) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LOCKOUT: state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end

        // A terminal count in the same cycle as a patrol grant starts a new period.
        if (patrol_tc) begin
            patrol_pending_d = 1'b1;
        end else if (grant_patrol) begin
            patrol_pending_d = 1'b0;
        end else begin
            patrol_pending_d = patrol_pending_q;
        end

        wait_cnt_d   = (state_d != state_q) ? '0 : wait_cnt_q + 1'b1;
        engage_req_d = (state_d == ST_ENGAGE);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q           <= ST_IDLE;
            patrol_cnt_q      <= '0;
            patrol_pending_q  <= 1'b0;
            wait_cnt_q        <= '0;
            scan_q            <= 1'b0;
            gnt_q             <= 1'b0;
            engage_req_q      <= 1'b0;
            abort_q           <= 1'b0;
            engage_distance_q <= 32'd0;
            scan_count_q      <= 8'd0;
            engage_count_q    <= 8'd0;
        end else begin
            state_q           <= state_d;
            patrol_cnt_q      <= patrol_cnt_d;
            patrol_pending_q  <= patrol_pending_d;
            wait_cnt_q        <= wait_cnt_d;
            scan_q            <= scan_d;
            gnt_q             <= gnt_d;
            engage_req_q      <= engage_req_d;
            abort_q           <= abort_d;
            engage_distance_q <= engage_distance_d;
            scan_count_q      <= scan_count_d;
            engage_count_q    <= engage_count_d;
        end
    end

    assign scan_for_target = scan_q;
    assign pilot_gnt       = gnt_q;
    assign engage_req      = engage_req_q;
    assign engage_distance = engage_distance_q;
    assign abort           = abort_q;
    assign scan_count      = scan_count_q;
    assign engage_count    = engage_count_q;
    assign seq_state       = state_q;

endmodule

// File: tb/tb_engagement_sequencer.sv
// tb/tb_engagement_sequencer.sv - directed self-checking bench for engagement_sequencer
module tb_engagement_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        pilot_req;
    logic [1:0]  artau_state;
    logic        threat_detected;
    logic [31:0] distance_to_target;
    logic [1:0]  ecsu_state;
    logic        alert;
    logic        engage_ack;
    logic        scan_for_target;
    logic        pilot_gnt;
    logic        engage_req;
    logic [31:0] engage_distance;
    logic        abort;
    logic [7:0]  scan_count;
    logic [7:0]  engage_count;
    logic [2:0]  seq_state;

    logic        arb_rst_n;
    logic        arb_pilot_req;
    logic        arb_scan;
    logic        arb_gnt;
    logic        arb_engage_req;
    logic [31:0] arb_engage_distance;
    logic        arb_abort;
    logic [7:0]  arb_scan_count;
    logic [7:0]  arb_engage_count;
    logic [2:0]  arb_seq_state;

    int n_checks = 0;
    int n_errors = 0;

    engagement_sequencer #(.PATROL_PERIOD(5000)) dut (
        .CLK(clk), .RST(rst_n), .pilot_req(pilot_req), .artau_state(artau_state),
        .threat_detected(threat_detected), .distance_to_target(distance_to_target),
        .ecsu_state(ecsu_state), .emergency_landing_alert(alert), .engage_ack(engage_ack),
        .scan_for_target(scan_for_target), .pilot_gnt(pilot_gnt), .engage_req(engage_req),
        .engage_distance(engage_distance), .abort(abort), .scan_count(scan_count),
        .engage_count(engage_count), .seq_state(seq_state)
    );

    engagement_sequencer #(.PATROL_PERIOD(20), .SCAN_TIMEOUT(8), .COOLDOWN(4)) dut_arb (
        .CLK(clk), .RST(arb_rst_n), .pilot_req(arb_pilot_req), .artau_state(2'b00),
        .threat_detected(1'b0), .distance_to_target(32'd0),
        .ecsu_state(2'b00), .emergency_landing_alert(1'b0), .engage_ack(1'b0),
        .scan_for_target(arb_scan), .pilot_gnt(arb_gnt), .engage_req(arb_engage_req),
        .engage_distance(arb_engage_distance), .abort(arb_abort), .scan_count(arb_scan_count),
        .engage_count(arb_engage_count), .seq_state(arb_seq_state)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_seq(input logic [2:0] exp, input int budget, input string tag);
        int n = 0;
        while (seq_state !== exp && n < budget) begin
            step();
            n++;
        end
        check_eq(tag, seq_state, exp);
    endtask

    task automatic scan_to_done();
        pilot_req = 1'b1;
        step();
        check_eq("s2d_scan", scan_for_target, 1);
        pilot_req   = 1'b0;
        artau_state = 2'b01;
        step();
        step();
        check_eq("s2d_wait_done", seq_state, 3);
    endtask

    task automatic wait_arb_scan(input string tag);
        int n = 0;
        while (arb_scan !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        check_eq(tag, arb_scan, 1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; arb_rst_n = 1'b0;
        pilot_req = 1'b0; artau_state = 2'b00; threat_detected = 1'b0;
        distance_to_target = 32'd0; ecsu_state = 2'b00; alert = 1'b0; engage_ack = 1'b0;
        arb_pilot_req = 1'b0;
        repeat (3) step();

        check_eq("rst_state", seq_state, 0);
        check_eq("rst_outs", {scan_for_target, pilot_gnt, engage_req, abort}, 0);
        check_eq("rst_dist", engage_distance, 0);
        check_eq("rst_counts", {scan_count, engage_count}, 0);
        rst_n = 1'b1;

        // Pilot scan, no threat
        pilot_req = 1'b1;
        step();
        check_eq("p_scan", scan_for_target, 1);
        check_eq("p_gnt", pilot_gnt, 1);
        check_eq("p_state_scan", seq_state, 1);
        pilot_req = 1'b0; artau_state = 2'b01;
        step();
        check_eq("p_state_wb", seq_state, 2);
        check_eq("p_scan_once", {scan_for_target, pilot_gnt}, 0);
        step();
        check_eq("p_state_wd", seq_state, 3);
        artau_state = 2'b10;
        step();
        check_eq("p_state_wd2", seq_state, 3);
        artau_state = 2'b00;
        step();
        check_eq("p_state_hold", seq_state, 5);
        check_eq("p_scan_count", scan_count, 1);
        n = 0;
        while (seq_state == 3'd5 && n < 100) begin
            n++;
            step();
        end
        check_eq("p_hold_cycles", n, 16);
        check_eq("p_idle", seq_state, 0);

        // Engage path with ack after 3 cycles
        scan_to_done();
        threat_detected = 1'b1; distance_to_target = 32'd5000; ecsu_state = 2'b01;
        step();
        check_eq("e_state", seq_state, 4);
        check_eq("e_dist", engage_distance, 5000);
        threat_detected = 1'b0; artau_state = 2'b00;
        n = 0;
        if (engage_req) n++;
        repeat (3) begin
            step();
            if (engage_req) n++;
        end
        engage_ack = 1'b1;
        step();
        engage_ack = 1'b0;
        check_eq("e_req_cycles", n, 4);
        check_eq("e_req_drop", engage_req, 0);
        check_eq("e_hold", seq_state, 5);
        check_eq("e_count", engage_count, 1);
        check_eq("e_no_abort", abort, 0);
        check_eq("e_scan_count", scan_count, 2);
        wait_seq(3'd0, 40, "e_back_idle");

        // Weather veto
        scan_to_done();
        threat_detected = 1'b1; ecsu_state = 2'b10;
        step();
        check_eq("v_hold", seq_state, 5);
        check_eq("v_no_req", engage_req, 0);
        check_eq("v_scan_count", scan_count, 3);
        threat_detected = 1'b0; ecsu_state = 2'b00; artau_state = 2'b00;
        wait_seq(3'd0, 40, "v_back_idle");

        // Withdrawal on EMERGENCY weather during ENGAGE
        scan_to_done();
        threat_detected = 1'b1; distance_to_target = 32'd1234;
        step();
        check_eq("w_engage", seq_state, 4);
        threat_detected = 1'b0; artau_state = 2'b00; ecsu_state = 2'b11;
        step();
        check_eq("w_abort", abort, 1);
        check_eq("w_req_drop", engage_req, 0);
        check_eq("w_hold", seq_state, 5);
        step();
        check_eq("w_abort_pulse", abort, 0);
        ecsu_state = 2'b00;
        wait_seq(3'd0, 40, "w_back_idle");
        check_eq("w_dist_held", engage_distance, 1234);
        check_eq("w_eng_count", engage_count, 1);
        check_eq("w_scan_count", scan_count, 4);

        // Emergency landing alert during ENGAGE
        scan_to_done();
        threat_detected = 1'b1; distance_to_target = 32'd777;
        step();
        check_eq("m_engage", seq_state, 4);
        threat_detected = 1'b0; artau_state = 2'b00; alert = 1'b1;
        step();
        check_eq("m_lockout", seq_state, 6);
        check_eq("m_req_abort", {engage_req, abort}, 0);
        step();
        check_eq("m_lockout_hold", seq_state, 6);
        alert = 1'b0;
        step();
        check_eq("m_exit_idle", seq_state, 0);
        step();
        check_eq("m_stay_idle", seq_state, 0);
        check_eq("m_scan_count", scan_count, 5);

        // WAIT_BUSY timeout with radar stuck idle
        pilot_req = 1'b1;
        step();
        check_eq("t_scan", scan_for_target, 1);
        pilot_req = 1'b0;
        step();
        n = 0;
        while (seq_state == 3'd2 && n < 400) begin
            n++;
            step();
        end
        check_eq("t_wb_cycles", n, 255);
        check_eq("t_hold", seq_state, 5);
        check_eq("t_abort", abort, 1);
        check_eq("t_scan_count", scan_count, 6);
        step();
        check_eq("t_abort_pulse", abort, 0);
        wait_seq(3'd0, 40, "t_back_idle");

        // Reset asserted mid-handshake
        scan_to_done();
        threat_detected = 1'b1; distance_to_target = 32'd999;
        step();
        check_eq("r_req", engage_req, 1);
        threat_detected = 1'b0; artau_state = 2'b00;
        rst_n = 1'b0;
        step();
        check_eq("r_state", seq_state, 0);
        check_eq("r_outs", {scan_for_target, pilot_gnt, engage_req, abort}, 0);
        check_eq("r_dist", engage_distance, 0);
        check_eq("r_counts", {scan_count, engage_count}, 0);
        rst_n = 1'b1;

        // Arbitration: pilot beats pending patrol, then patrol is granted and cleared
        arb_pilot_req = 1'b1;
        arb_rst_n = 1'b1;
        for (int g = 0; g < 4; g++) begin
            wait_arb_scan("a_pilot_scan");
            check_eq("a_pilot_gnt", arb_gnt, 1);
            step();
        end
        check_eq("a_pending_held", dut_arb.patrol_pending_q, 1);
        arb_pilot_req = 1'b0;
        wait_arb_scan("a_patrol_scan");
        check_eq("a_patrol_gnt", arb_gnt, 0);
        check_eq("a_pending_clr", dut_arb.patrol_pending_q, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
